// File: rtl/pwm_pkg.sv
// Shared constants for the PWM/DDS oscillator slice: datapath widths and
// waveform-select encodings.
package pwm_pkg;

    localparam int PHASE_WIDTH      = 32;
    localparam int DUTY_WIDTH       = 8;
    localparam int DROP_COUNT_WIDTH = 16;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_PULSE  = 2'd3;

endpackage

// File: rtl/pwm_wave_shaper.sv
// Combinational waveform shaper: maps the top W+1 phase bits and a wave select
// to an unscaled W-bit sample. The parent registers the result.
module pwm_wave_shaper
#(
    parameter int W = pwm_pkg::DUTY_WIDTH
) (
    input  logic [W:0]   phase_msbs,
    input  logic [1:0]   wave_sel,
    input  logic         silent,
    output logic [W-1:0] wave
);
    import pwm_pkg::*;

    always_comb begin
        // NOTE: default first so every path assigns wave and no latch is inferred.
        wave = '0;
        if (!silent) begin
            case (wave_sel)
                WAVE_SQUARE: wave = phase_msbs[W] ? '1 : '0;
                WAVE_SAW:    wave = phase_msbs[W:1];
                WAVE_TRI:    wave = phase_msbs[W] ? ~phase_msbs[W-1:0] : phase_msbs[W-1:0];
                WAVE_PULSE:  wave = (phase_msbs[W:W-1] == 2'b00) ? '1 : '0;
                default:     wave = '0;
            endcase
        end
    end

endmodule

// File: rtl/pwm_dds_oscillator.sv
// DDS oscillator: phase accumulator -> wave shaper -> amplitude scaler -> output holder.
// Define PWM_DDS_PHASE_SYNC_EN to restart the phase whenever the phase delta changes.
module pwm_dds_oscillator
#(
    parameter int PHASE_WIDTH = pwm_pkg::PHASE_WIDTH,
    parameter int DUTY_WIDTH  = pwm_pkg::DUTY_WIDTH,
    parameter int SAMPLE_DIV  = 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [PHASE_WIDTH-1:0]                i_phase_delta,
    input  logic [DUTY_WIDTH-1:0]                 i_top,
    input  logic                                  i_top_valid,
    input  logic [1:0]                            i_wave_sel,
    output logic [DUTY_WIDTH-1:0]                 o_duty,
    output logic                                  o_duty_valid,
    input  logic                                  i_duty_ready,
    output logic [pwm_pkg::DROP_COUNT_WIDTH-1:0]  o_drop_count
);
    import pwm_pkg::*;

    localparam int DIV_WIDTH = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SAMPLE_DIV - 1);

    logic [DIV_WIDTH-1:0]   div_cnt;
    logic                   tick;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] phase_next;
    logic [DUTY_WIDTH-1:0]  top;
    logic                   s1_valid;
    logic                   s1_silent;
    logic [DUTY_WIDTH-1:0]  shaped;
    logic [DUTY_WIDTH-1:0]  wave;
    logic                   s2_valid;
    logic [DUTY_WIDTH:0]    top_plus1;
    logic [2*DUTY_WIDTH:0]  product;
    logic [DUTY_WIDTH-1:0]  scaled;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + DIV_WIDTH'(1);
    end

`ifdef PWM_DDS_PHASE_SYNC_EN
    logic [PHASE_WIDTH-1:0] prev_delta;

    always_ff @(posedge i_clk) begin
        if (i_rst)     prev_delta <= '0;
        else if (tick) prev_delta <= i_phase_delta;
    end

    // A new note restarts the accumulator as if it had been at zero.
    assign phase_next = (i_phase_delta != prev_delta) ? i_phase_delta
                                                      : phase + i_phase_delta;
`else
    assign phase_next = phase + i_phase_delta;
`endif

    // Stage 1: accumulate; a zero delta marks the sample as silent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase     <= '0;
            s1_valid  <= 1'b0;
            s1_silent <= 1'b0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                phase     <= phase_next;
                s1_silent <= (i_phase_delta == '0);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)            top <= '1;
        else if (i_top_valid) top <= i_top;
    end

    pwm_wave_shaper #(.W(DUTY_WIDTH)) u_shaper (
        .phase_msbs (phase[PHASE_WIDTH-1 -: DUTY_WIDTH+1]),
        .wave_sel   (i_wave_sel),
        .silent     (s1_silent),
        .wave       (shaped)
    );

    // Stage 2: register the shaped wave.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wave     <= '0;
            s2_valid <= 1'b0;
        end else begin
            wave     <= shaped;
            s2_valid <= s1_valid;
        end
    end

    // Scaling by top+1 lets top=all-ones pass the wave through unchanged.
    assign top_plus1 = {1'b0, top} + (DUTY_WIDTH+1)'(1);
    assign product   = (2*DUTY_WIDTH+1)'(wave) * (2*DUTY_WIDTH+1)'(top_plus1);
    assign scaled    = DUTY_WIDTH'(product >> DUTY_WIDTH);

    // Stage 3: output holder; the latest sample always wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_duty       <= '0;
            o_duty_valid <= 1'b0;
            o_drop_count <= '0;
        end else if (s2_valid) begin
            o_duty       <= scaled;
            o_duty_valid <= 1'b1;
            if (o_duty_valid && !i_duty_ready && (o_drop_count != '1))
                o_drop_count <= o_drop_count + DROP_COUNT_WIDTH'(1);
        end else if (i_duty_ready) begin
            o_duty_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_dds_oscillator.sv
// Self-checking bench for pwm_dds_oscillator: table vectors, hand-written
// corner sequences and randomized stimulus against a sample-level model.
module tb_pwm_dds_oscillator;

    localparam int SAMPLE_DIV = 1;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_phase_delta;
    logic [7:0]  i_top;
    logic        i_top_valid;
    logic [1:0]  i_wave_sel;
    logic [7:0]  o_duty;
    logic        o_duty_valid;
    logic        i_duty_ready;
    logic [15:0] o_drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_dds_oscillator #(
        .PHASE_WIDTH (32),
        .DUTY_WIDTH  (8),
        .SAMPLE_DIV  (SAMPLE_DIV)
    ) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_phase_delta (i_phase_delta),
        .i_top         (i_top),
        .i_top_valid   (i_top_valid),
        .i_wave_sel    (i_wave_sel),
        .o_duty        (o_duty),
        .o_duty_valid  (o_duty_valid),
        .i_duty_ready  (i_duty_ready),
        .o_drop_count  (o_drop_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Reference model: each tick produces a sample record that is shaped
    // one edge later and scaled/delivered two edges later.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] p;
        bit          silent;
        int          wave;
        int          wave_cyc;
        int          scale_cyc;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] m_phase;
    logic [31:0] m_prev;
    int          m_top;
    int          m_duty;
    bit          m_valid;
    int          m_drop;
    int          m_div;
    int          m_cyc = 0;

    function automatic int shape(input logic [31:0] p, input logic [1:0] sel);
        longint unsigned u;
        longint unsigned t;
        u = longint'(p);
        t = u >> 23;
        case (sel)
            2'd0:    return (u >= 64'h8000_0000) ? 255 : 0;
            2'd1:    return int'(u >> 24);
            2'd2:    return (t < 256) ? int'(t) : int'(511 - t);
            default: return (u < 64'h4000_0000) ? 255 : 0;
        endcase
    endfunction

    task automatic model_edge();
        bit    arrived;
        int    fresh;
        pend_t e;
        arrived = 1'b0;
        fresh   = 0;
        if (i_rst) begin
            pend.delete();
            m_phase = '0;
            m_prev  = '0;
            m_top   = 255;
            m_duty  = 0;
            m_valid = 1'b0;
            m_drop  = 0;
            m_div   = 0;
        end else begin
            if (pend.size() > 0 && pend[0].scale_cyc == m_cyc) begin
                fresh   = (pend[0].wave * (m_top + 1)) / 256;
                arrived = 1'b1;
                pend.delete(0);
            end
            if (arrived) begin
                if (m_valid && !i_duty_ready && m_drop < 65535) m_drop++;
                m_duty  = fresh;
                m_valid = 1'b1;
            end else if (m_valid && i_duty_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < pend.size(); i++)
                if (pend[i].wave_cyc == m_cyc)
                    pend[i].wave = pend[i].silent ? 0 : shape(pend[i].p, i_wave_sel);
            if (m_div == SAMPLE_DIV - 1) begin
`ifdef PWM_DDS_PHASE_SYNC_EN
                if (i_phase_delta != m_prev) m_phase = i_phase_delta;
                else                         m_phase = m_phase + i_phase_delta;
                m_prev = i_phase_delta;
`else
                m_phase = m_phase + i_phase_delta;
`endif
                e.p         = m_phase;
                e.silent    = (i_phase_delta == 32'd0);
                e.wave      = 0;
                e.wave_cyc  = m_cyc + 1;
                e.scale_cyc = m_cyc + 2;
                pend.push_back(e);
                m_div = 0;
            end else begin
                m_div++;
            end
            if (i_top_valid) m_top = int'(i_top);
        end
        m_cyc++;
    endtask

    // ------------------------------------------------------------------
    // Drivers and checking
    // ------------------------------------------------------------------
    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // One reset edge; afterwards we are in cycle 0 (the first tick cycle).
    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setup(input logic [1:0] sel, input logic [31:0] delta, input bit ready);
        i_wave_sel    = sel;
        i_phase_delta = delta;
        i_duty_ready  = ready;
        i_top_valid   = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  top;
        logic [31:0] delta;
        int          sample;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{2'd1, 8'hFF, 32'h0100_0000,   1, 8'h01};
        vecs[1]  = '{2'd1, 8'hFF, 32'h0100_0000, 255, 8'hFF};
        vecs[2]  = '{2'd1, 8'hFF, 32'h0100_0000, 256, 8'h00};
        vecs[3]  = '{2'd0, 8'h7F, 32'h0200_0000,  63, 8'h00};
        vecs[4]  = '{2'd0, 8'h7F, 32'h0200_0000,  64, 8'h7F};
        vecs[5]  = '{2'd0, 8'h7F, 32'h0200_0000, 127, 8'h7F};
        vecs[6]  = '{2'd0, 8'h7F, 32'h0200_0000, 128, 8'h00};
        vecs[7]  = '{2'd2, 8'hFF, 32'h0100_0000,   1, 8'h02};
        vecs[8]  = '{2'd2, 8'hFF, 32'h0100_0000,  64, 8'h80};
        vecs[9]  = '{2'd2, 8'hFF, 32'h0100_0000, 128, 8'hFF};
        vecs[10] = '{2'd2, 8'hFF, 32'h0100_0000, 192, 8'h7F};
        vecs[11] = '{2'd3, 8'hFF, 32'h0100_0000,   1, 8'hFF};
        vecs[12] = '{2'd3, 8'hFF, 32'h0100_0000,  64, 8'h00};
        vecs[13] = '{2'd1, 8'h3F, 32'h0100_0000, 128, 8'h20};
        vecs[14] = '{2'd0, 8'h00, 32'h0200_0000,  64, 8'h00};
        vecs[15] = '{2'd1, 8'h80, 32'h4000_0000,   3, 8'h60};

        i_rst = 1'b1;
        i_top = 8'hFF;
        setup(2'd1, 32'h0100_0000, 1'b1);

        // Reset state and 3-cycle latency, then a full saw period.
        do_reset();
        check("reset_valid", 32'(o_duty_valid), 32'd0);
        check("reset_duty",  32'(o_duty),       32'd0);
        check("reset_drops", 32'(o_drop_count), 32'd0);
        step();
        check("latency_c1_valid", 32'(o_duty_valid), 32'd0);
        step();
        check("latency_c2_valid", 32'(o_duty_valid), 32'd0);
        for (int k = 1; k <= 258; k++) begin
            step();
            check("saw_run_valid", 32'(o_duty_valid), 32'd1);
            check("saw_run_duty",  32'(o_duty),       32'(k % 256));
        end

        // Table vectors: shape and scale at specific sample indices.
        for (int v = 0; v < 16; v++) begin
            setup(vecs[v].sel, vecs[v].delta, 1'b1);
            i_top = vecs[v].top;
            do_reset();
            i_top_valid = 1'b1;
            step();
            i_top_valid = 1'b0;
            run(vecs[v].sample + 1);
            check($sformatf("vec%0d_valid", v), 32'(o_duty_valid), 32'd1);
            check($sformatf("vec%0d_duty", v),  32'(o_duty),       32'(vecs[v].exp));
        end

        // Backpressure: ten samples with ready low, then ready high.
        setup(2'd1, 32'h0100_0000, 1'b0);
        do_reset();
        run(12);
        check("bp_valid", 32'(o_duty_valid), 32'd1);
        check("bp_duty",  32'(o_duty),       32'h0A);
        check("bp_drops", 32'(o_drop_count), 32'd9);
        i_duty_ready = 1'b1;
        run(20);
        check("bp_after_duty",  32'(o_duty),       32'h1E);
        check("bp_after_drops", 32'(o_drop_count), 32'd9);

        // Rest: delta 0 silences output; restoring it resumes the saw.
        setup(2'd1, 32'h0100_0000, 1'b1);
        do_reset();
        run(10);
        i_phase_delta = 32'd0;
        run(2);
        check("rest_before", 32'(o_duty), 32'h0A);
        run(1);
        check("rest_first_silent", 32'(o_duty), 32'h00);
        run(2);
        i_phase_delta = 32'h0100_0000;
        check("rest_silent_c15", 32'(o_duty), 32'h00);
        run(2);
        check("rest_silent_c17", 32'(o_duty), 32'h00);
        run(1);
`ifdef PWM_DDS_PHASE_SYNC_EN
        check("resume_1", 32'(o_duty), 32'h01);
        run(1);
        check("resume_2", 32'(o_duty), 32'h02);
`else
        check("resume_1", 32'(o_duty), 32'h0B);
        run(1);
        check("resume_2", 32'(o_duty), 32'h0C);
`endif

        // Note change at phase 0x3000_0000.
        setup(2'd1, 32'h0100_0000, 1'b1);
        do_reset();
        run(48);
        i_phase_delta = 32'h0200_0000;
        run(2);
        check("note_before", 32'(o_duty), 32'h30);
        run(1);
`ifdef PWM_DDS_PHASE_SYNC_EN
        check("note_first",  32'(o_duty), 32'h02);
        run(1);
        check("note_second", 32'(o_duty), 32'h04);
`else
        check("note_first",  32'(o_duty), 32'h32);
        run(1);
        check("note_second", 32'(o_duty), 32'h34);
`endif

        // Mid-operation reset wins over a simultaneous top load.
        i_duty_ready = 1'b0;
        run(5);
        check("pre_reset_drops", 32'(o_drop_count != 16'd0), 32'd1);
        i_top       = 8'h10;
        i_top_valid = 1'b1;
        do_reset();
        setup(2'd1, 32'h0100_0000, 1'b1);
        check("midrst_valid", 32'(o_duty_valid), 32'd0);
        check("midrst_duty",  32'(o_duty),       32'd0);
        check("midrst_drops", 32'(o_drop_count), 32'd0);
        run(3);
        check("midrst_top_ff", 32'(o_duty), 32'h01);

        // Randomized stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 255) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       i_phase_delta = 32'd0;
                    1:       i_phase_delta = $urandom;
                    default: i_phase_delta = 32'($urandom_range(1, 255)) << 24;
                endcase
            end
            if ($urandom_range(0, 7) == 0) i_wave_sel = 2'($urandom_range(0, 3));
            i_top_valid  = ($urandom_range(0, 15) == 0);
            i_top        = 8'($urandom_range(0, 255));
            i_duty_ready = ($urandom_range(0, 3) != 0);
            step();
            check("rnd_valid_duty_drops",
                  {7'd0, o_duty_valid, o_duty, o_drop_count},
                  {7'd0, m_valid, 8'(m_duty), 16'(m_drop)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
